// File: rtl/monitor_sys_pkg.sv
// Shared definitions for the monitor MCU control block: command codes,
// decoder states and the core identification string.
package monitor_sys_pkg;

  localparam logic [7:0] CMD_ID    = 8'd1;
  localparam logic [7:0] CMD_CFG   = 8'd2;
  localparam logic [7:0] CMD_OVL   = 8'd3;
  localparam logic [7:0] CMD_COLOR = 8'd4;
  localparam logic [7:0] CMD_JOY1  = 8'd5;
  localparam logic [7:0] CMD_JOY2  = 8'd6;
  localparam logic [7:0] CMD_ROM   = 8'd7;

  // "CORE" + hex digit + NUL
  localparam int ID_LEN = 6;

  // IDLE: await command | ARGS: collect args | STREAM: ROM data | SKIP: ignore until CS end
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARGS,
    ST_STREAM,
    ST_SKIP
  } dec_state_t;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd >= CMD_ID) && (cmd <= CMD_ROM);
  endfunction

  function automatic logic [2:0] cmd_nargs(input logic [7:0] cmd);
    case (cmd)
      CMD_CFG:   return 3'd4;
      CMD_COLOR: return 3'd2;
      CMD_ROM:   return 3'd3;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] id_char(input logic [2:0] idx, input logic [3:0] core_id);
    logic [7:0] hex;
    hex = (core_id < 4'd10) ? (8'h30 + {4'h0, core_id}) : (8'h37 + {4'h0, core_id});
    case (idx)
      3'd0:    return 8'h43;
      3'd1:    return 8'h4F;
      3'd2:    return 8'h52;
      3'd3:    return 8'h45;
      3'd4:    return hex;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/monitor_sys_spi_slave_byte.sv
// SPI mode-0 slave byte front end: sspi_clk-domain shifters, plus the
// clk-domain byte strobe and end-of-transaction strobe.
module spi_slave_byte
  import monitor_sys_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sspi_cs,
  input  logic       i_sspi_clk,
  input  logic       i_sspi_mosi,
  output logic       o_sspi_miso,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_cs_end
);

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sh;
  logic [7:0] r_rx_byte;
  logic       r_rx_tog;
  logic [2:0] r_tog_s;
  logic [3:0] r_cs_s;

  always_ff @(posedge i_sspi_clk or posedge i_sspi_cs or posedge i_reset) begin
    if (i_reset || i_sspi_cs) begin
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_rx_sh   <= {r_rx_sh[5:0], i_sspi_mosi};
    end
  end

  // Holding register and toggle survive CS so the clk side can still pick them up.
  always_ff @(posedge i_sspi_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_byte <= '0;
      r_rx_tog  <= 1'b0;
    end else if (!i_sspi_cs && r_bit_cnt == 3'd7) begin
      r_rx_byte <= {r_rx_sh, i_sspi_mosi};
      r_rx_tog  <= ~r_rx_tog;
    end
  end

  // CS path is one stage longer so a frame's last byte always precedes its end strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tog_s <= '0;
      r_cs_s  <= '1;
    end else begin
      r_tog_s <= {r_tog_s[1:0], r_rx_tog};
      r_cs_s  <= {r_cs_s[2:0], i_sspi_cs};
    end
  end

  assign o_rx_valid  = r_tog_s[2] ^ r_tog_s[1];
  assign o_cs_end    = r_cs_s[2] & ~r_cs_s[3];
  assign o_rx_byte   = r_rx_byte;
  // tx byte only changes between frames, so indexing it by bit count is stable.
  assign o_sspi_miso = ~i_sspi_cs & i_tx_byte[3'd7 - r_bit_cnt];

endmodule

// File: rtl/monitor_sys.sv
// Monitor MCU command decoder: core ID readback, config word, flat overlay
// and ROM streaming, all driven from single-byte SPI commands.
module monitor_sys
  import monitor_sys_pkg::*;
#(
  parameter int FREQ    = 21_477_000,
  parameter int CORE_ID = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_overlay,
  input  logic [7:0]  i_overlay_x,
  input  logic [7:0]  i_overlay_y,
  output logic [14:0] o_overlay_color,
  input  logic [11:0] i_joy1,
  input  logic [11:0] i_joy2,
  output logic        o_rom_loading,
  output logic [7:0]  o_rom_do,
  output logic        o_rom_do_valid,
  output logic [31:0] o_core_config,
  input  logic        i_sspi_cs,
  input  logic        i_sspi_clk,
  input  logic        i_sspi_mosi,
  output logic        o_sspi_miso
);

  localparam logic [3:0] ID_NIB  = 4'(CORE_ID);
  localparam logic [2:0] PTR_NUL = 3'(ID_LEN - 1);

  if (FREQ <= 0) begin : g_freq_invalid
  end

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_cs_end;
  logic        w_unused_ok;

  dec_state_t  r_state;
  logic [7:0]  r_cmd;
  logic [2:0]  r_arg_left;
  logic [31:0] r_arg_sh;
  logic        r_done;
  logic [23:0] r_len;
  logic        r_rd_id;
  logic [2:0]  r_ptr;
  logic [7:0]  r_tx;
  logic        r_overlay;
  logic [14:0] r_color;
  logic [31:0] r_config;
  logic        r_loading;
  logic [7:0]  r_rom_do;
  logic        r_rom_valid;

  assign w_unused_ok = ^{i_overlay_x, i_overlay_y, i_joy1[11:8], i_joy2[11:8]};

  spi_slave_byte u_spi (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_sspi_cs   (i_sspi_cs),
    .i_sspi_clk  (i_sspi_clk),
    .i_sspi_mosi (i_sspi_mosi),
    .o_sspi_miso (o_sspi_miso),
    .i_tx_byte   (r_tx),
    .o_rx_byte   (w_rx_byte),
    .o_rx_valid  (w_rx_valid),
    .o_cs_end    (w_cs_end)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_arg_left  <= '0;
      r_arg_sh    <= '0;
      r_done      <= 1'b0;
      r_len       <= '0;
      r_rd_id     <= 1'b0;
      r_ptr       <= '0;
      r_tx        <= '0;
      r_overlay   <= 1'b0;
      r_color     <= '0;
      r_config    <= '0;
      r_loading   <= 1'b0;
      r_rom_do    <= '0;
      r_rom_valid <= 1'b0;
    end else begin
      r_rom_valid <= 1'b0;
      if (w_cs_end) begin
        if (r_done) begin
          r_rd_id <= 1'b0;
          r_tx    <= '0;
          case (r_cmd)
            CMD_ID: begin
              r_rd_id <= 1'b1;
              r_ptr   <= '0;
              r_tx    <= id_char(3'd0, ID_NIB);
            end
            CMD_CFG:   r_config <= r_arg_sh;
            CMD_OVL:   r_overlay <= r_arg_sh[0];
            CMD_COLOR: r_color <= r_arg_sh[14:0];
            CMD_JOY1:  r_tx <= i_joy1[7:0];
            CMD_JOY2:  r_tx <= i_joy2[7:0];
            default: ;
          endcase
        end else if (!cmd_valid(r_cmd)) begin
          // A frame without a command is a read: step the ID string, saturating on NUL.
          if (r_rd_id) begin
            if (r_ptr != PTR_NUL) begin
              r_ptr <= r_ptr + 3'd1;
              r_tx  <= id_char(r_ptr + 3'd1, ID_NIB);
            end
          end else begin
            r_tx <= '0;
          end
        end
        r_state   <= ST_IDLE;
        r_cmd     <= '0;
        r_done    <= 1'b0;
        r_loading <= 1'b0;
      end else if (w_rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            r_cmd    <= w_rx_byte;
            r_arg_sh <= '0;
            if (cmd_valid(w_rx_byte)) begin
              r_arg_left <= cmd_nargs(w_rx_byte);
              r_state    <= ST_ARGS;
            end else begin
              r_state <= ST_SKIP;
            end
          end
          ST_ARGS: begin
            r_arg_sh   <= {r_arg_sh[23:0], w_rx_byte};
            r_arg_left <= r_arg_left - 3'd1;
            if (r_arg_left == 3'd1) begin
              r_done <= 1'b1;
              if (r_cmd == CMD_ROM) begin
                r_len <= {r_arg_sh[15:0], w_rx_byte};
                if ({r_arg_sh[15:0], w_rx_byte} != 24'd0) begin
                  r_loading <= 1'b1;
                  r_state   <= ST_STREAM;
                end else begin
                  r_state <= ST_SKIP;
                end
              end else begin
                r_state <= ST_SKIP;
              end
            end
          end
          ST_STREAM: begin
            r_rom_do    <= w_rx_byte;
            r_rom_valid <= 1'b1;
            r_len       <= r_len - 24'd1;
            if (r_len == 24'd1) begin
              r_loading <= 1'b0;
              r_state   <= ST_SKIP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_overlay       = r_overlay;
  assign o_overlay_color = r_color;
  assign o_core_config   = r_config;
  assign o_rom_loading   = r_loading;
  assign o_rom_do        = r_rom_do;
  assign o_rom_do_valid  = r_rom_valid;

endmodule

// File: tb/tb_monitor_sys.sv
// Directed bench for monitor_sys: drives SPI frames as the monitor MCU would
// and compares outputs against hand-computed values.
module tb_monitor_sys;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        overlay;
  logic [7:0]  overlay_x = 8'd0;
  logic [7:0]  overlay_y = 8'd0;
  logic [14:0] overlay_color;
  logic [11:0] joy1 = 12'h0A5;
  logic [11:0] joy2 = 12'h35A;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic [31:0] core_config;
  logic        sspi_cs = 1'b1;
  logic        sspi_clk = 1'b0;
  logic        sspi_mosi = 1'b0;
  logic        sspi_miso;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] tb_buf [0:7];
  logic [7:0] rx_buf [0:7];
  logic [7:0] id_exp [0:5] = '{8'h43, 8'h4F, 8'h52, 8'h45, 8'h31, 8'h00};

  int         rom_cnt = 0;
  int         load_cycles = 0;
  logic [7:0] rom_log [0:15];

  always #23 clk = ~clk;

  monitor_sys #(.FREQ(21_477_000), .CORE_ID(1)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .o_overlay       (overlay),
    .i_overlay_x     (overlay_x),
    .i_overlay_y     (overlay_y),
    .o_overlay_color (overlay_color),
    .i_joy1          (joy1),
    .i_joy2          (joy2),
    .o_rom_loading   (rom_loading),
    .o_rom_do        (rom_do),
    .o_rom_do_valid  (rom_do_valid),
    .o_core_config   (core_config),
    .i_sspi_cs       (sspi_cs),
    .i_sspi_clk      (sspi_clk),
    .i_sspi_mosi     (sspi_mosi),
    .o_sspi_miso     (sspi_miso)
  );

  always @(negedge clk) begin
    if (rom_loading) load_cycles++;
    if (rom_do_valid) begin
      if (rom_cnt < 16) rom_log[rom_cnt] = rom_do;
      rom_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 10 MHz mode 0 frame; MISO sampled just before each rising edge.
  task automatic run_frame(input int n);
    sspi_cs = 1'b0;
    #100;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        sspi_mosi = tb_buf[b][i];
        #50;
        rx_buf[b][i] = sspi_miso;
        sspi_clk = 1'b1;
        #50;
        sspi_clk = 1'b0;
      end
    end
    #100;
    sspi_cs = 1'b1;
    #300;
  endtask

  initial begin
    int   base_cnt;
    int   base_load;
    int   span;
    logic found;

    #100;
    check("rst_overlay", 32'(overlay), 32'd0);
    check("rst_color", 32'(overlay_color), 32'd0);
    check("rst_config", core_config, 32'd0);
    check("rst_loading", 32'(rom_loading), 32'd0);
    check("rst_rom_do", 32'(rom_do), 32'd0);
    check("rst_rom_valid", 32'(rom_do_valid), 32'd0);
    check("rst_miso", 32'(sspi_miso), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #200;

    tb_buf[0] = 8'h01; tb_buf[1] = 8'h00;
    run_frame(2);
    tb_buf[0] = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      run_frame(1);
      if (i < 6) check("id_byte", 32'(rx_buf[0]), 32'(id_exp[i]));
      if (rx_buf[0] == 8'h00) found = 1'b1;
    end
    check("id_nul_seen", 32'(found), 32'd1);
    run_frame(1);
    check("id_after_nul", 32'(rx_buf[0]), 32'd0);

    tb_buf[0] = 8'h02; tb_buf[1] = 8'hA5; tb_buf[2] = 8'hA5; tb_buf[3] = 8'hA5; tb_buf[4] = 8'hA5;
    run_frame(5);
    check("cfg_write", core_config, 32'hA5A5A5A5);

    tb_buf[0] = 8'h03; tb_buf[1] = 8'h01;
    run_frame(2);
    check("ovl_on", 32'(overlay), 32'd1);
    tb_buf[0] = 8'h04; tb_buf[1] = 8'h7C; tb_buf[2] = 8'h1F;
    run_frame(3);
    check("ovl_color", 32'(overlay_color), 32'h7C1F);

    tb_buf[0] = 8'h05; tb_buf[1] = 8'h00;
    run_frame(2);
    tb_buf[0] = 8'h00;
    run_frame(1);
    check("joy1_read", 32'(rx_buf[0]), 32'hA5);
    tb_buf[0] = 8'h06; tb_buf[1] = 8'h00;
    run_frame(2);
    tb_buf[0] = 8'h00;
    run_frame(1);
    check("joy2_read", 32'(rx_buf[0]), 32'h5A);

    base_cnt = rom_cnt; base_load = load_cycles;
    tb_buf[0] = 8'h07; tb_buf[1] = 8'h00; tb_buf[2] = 8'h00; tb_buf[3] = 8'h03;
    tb_buf[4] = 8'h11; tb_buf[5] = 8'h22; tb_buf[6] = 8'h33;
    run_frame(7);
    check("rom_count", 32'(rom_cnt - base_cnt), 32'd3);
    check("rom_b0", 32'(rom_log[base_cnt]), 32'h11);
    check("rom_b1", 32'(rom_log[base_cnt + 1]), 32'h22);
    check("rom_b2", 32'(rom_log[base_cnt + 2]), 32'h33);
    // loading spans three byte times (~52 clk) from length to last data byte
    span = load_cycles - base_load;
    check("rom_load_span", 32'(span >= 45 && span <= 60), 32'd1);
    check("rom_load_end", 32'(rom_loading), 32'd0);

    base_cnt = rom_cnt; base_load = load_cycles;
    tb_buf[0] = 8'h07; tb_buf[1] = 8'h00; tb_buf[2] = 8'h00; tb_buf[3] = 8'h00;
    run_frame(4);
    check("rom0_count", 32'(rom_cnt - base_cnt), 32'd0);
    check("rom0_load", 32'(load_cycles - base_load), 32'd0);

    base_cnt = rom_cnt;
    tb_buf[0] = 8'h07; tb_buf[1] = 8'h00; tb_buf[2] = 8'h00; tb_buf[3] = 8'h05; tb_buf[4] = 8'hAA;
    run_frame(5);
    check("rom_abort_count", 32'(rom_cnt - base_cnt), 32'd1);
    check("rom_abort_byte", 32'(rom_log[base_cnt]), 32'hAA);
    check("rom_abort_load", 32'(rom_loading), 32'd0);

    tb_buf[0] = 8'h02; tb_buf[1] = 8'h12; tb_buf[2] = 8'h34;
    run_frame(3);
    check("cfg_abort", core_config, 32'hA5A5A5A5);
    tb_buf[0] = 8'h03; tb_buf[1] = 8'h00;
    run_frame(2);
    check("post_abort_ovl", 32'(overlay), 32'd0);
    check("post_abort_color", 32'(overlay_color), 32'h7C1F);

    tb_buf[0] = 8'h09; tb_buf[1] = 8'h03; tb_buf[2] = 8'h01;
    run_frame(3);
    check("unknown_cmd", 32'(overlay), 32'd0);
    tb_buf[0] = 8'h03; tb_buf[1] = 8'h01;
    run_frame(2);
    check("post_unknown_ovl", 32'(overlay), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_sys.md
# monitor_sys

SPI-slave control block sitting between an external monitor MCU and the emulated core. It decodes single-byte commands on an SPI slave port, returns a core-identification string, and holds the 32-bit core configuration word. It drives a flat-colour on-screen overlay and streams ROM images into the core. All control logic runs in the core clock domain.

## Interface
Parameters:
- FREQ, 21_477_000: clk frequency in Hz; informational, no functional effect.
- CORE_ID, 1: core identifier, 0..15, embedded in the ID string.

Ports:
- clk  in  1  sole system clock; all logic except the SPI shifter runs on it.
- reset  in  1  asynchronous, active-high reset.
- overlay  out  1  overlay enable.
- overlay_x  in  8  current pixel x; unused by the flat-colour overlay.
- overlay_y  in  8  current pixel y; unused by the flat-colour overlay.
- overlay_color  out  15  RGB555 overlay colour.
- joy1, joy2  in  12  joystick state, readable over SPI.
- rom_loading  out  1  high while a ROM stream is in progress.
- rom_do  out  8  ROM data byte.
- rom_do_valid  out  1  one-clk strobe per ROM byte.
- core_config  out  32  configuration word.
- sspi_cs  in  1  chip select, active low.
- sspi_clk  in  1  SPI clock, mode 0, up to 10 MHz.
- sspi_mosi  in  1  data in, MSB first.
- sspi_miso  out  1  data out, MSB first.

## Operation
- Reset values:
  - overlay = 0, overlay_color = 0, core_config = 0.
  - rom_loading = 0, rom_do = 0, rom_do_valid = 0.
  - sspi_miso = 0; decoder in IDLE.
- SPI front end:
  - Shifter is clocked on sspi_clk rising edge and cleared while sspi_cs = 1.
  - Each completed byte is handed to the clk domain through a toggle plus 2-flop synchronizer.
  - A rising edge of sspi_cs, synchronized into clk, ends the transaction.
- MISO:
  - On the falling edge of sspi_cs, the shifter loads the tx byte and drives its bit 7.
  - Each sspi_clk rising edge shifts out the next bit.
- Decoder states:
  - IDLE: the first byte of a transaction is the command.
  - ARGS: collect the argument bytes.
  - STREAM: command 7 data phase.
  - Back to IDLE at transaction end.
- Commands:
  - 1: 1 dummy argument byte. Resets the string pointer.
    - Each following transaction returns the next byte of the string "CORE" + ASCII hex digit of CORE_ID + 0x00.
    - After the NUL, further reads return 0x00.
  - 2: 4 argument bytes, MSB first, written to core_config at transaction end.
  - 3: 1 argument byte; overlay = bit 0.
  - 4: 2 argument bytes; overlay_color = bits [14:0] of the 16-bit value.
  - 5 / 6: 1 dummy argument byte; the next read transaction returns joy1[7:0] / joy2[7:0].
  - 7: 3-byte length L (MSB first), then L data bytes.
    - rom_loading rises after the length is received and falls after the L-th byte.
    - If L = 0, rom_loading never rises.
    - Each data byte appears on rom_do with a one-clk rom_do_valid pulse.
  - Unknown command: following bytes are ignored until transaction end.
- Read transactions (a CS frame that follows a read setup) return the tx byte; MOSI content is ignored.
- If CS rises mid-command, partial arguments are discarded and registers are unchanged.
- If CS rises mid-stream, rom_loading drops.

## Timing
- core_config, overlay and overlay_color update within 4 clk after sspi_cs rises.
- The next tx byte is ready within 4 clk after sspi_cs rises; the master guarantees at least 300 ns before the next CS fall.
- rom_do_valid is asserted within 4 clk of each byte's 8th rising edge.
- Back-to-back SPI bytes arrive at least 17 clk apart at 10 MHz SPI; no backpressure.

## Structure
- Shared package: command codes (CMD_ID=1, CMD_CFG=2, CMD_OVL=3, CMD_COLOR=4, CMD_JOY1=5, CMD_JOY2=6, CMD_ROM=7), decoder state enum, ID string length.
- One sub-module `spi_slave_byte`: sspi_clk shifter, MISO shifter, clk-domain byte strobe and CS-end strobe.

## Test plan
- Reset, then command 1 with 0x00, then up to 64 read frames.
  - Response: 43 4F 52 45 31 00 with CORE_ID = 1; the terminating 0x00 arrives within 64 reads.
- Command 2 with 0xA5A5A5A5.
  - core_config = 32'hA5A5A5A5 within 300 ns of CS high.
- Command 3 with 0x01, then command 4 with 0x7C1F.
  - overlay = 1, overlay_color = 15'h7C1F.
- Command 5, then one read frame with joy1 = 12'h0A5.
  - Byte read = 0xA5.
- Command 7 with length 3 and data 11 22 33.
  - Three rom_do_valid pulses carrying 11, 22, 33.
  - rom_loading high during the stream and low afterwards.
- Command 2 with CS raised after 2 argument bytes.
  - core_config unchanged; the next command decodes normally.
